// File: rtl/mmac_tile_sequencer.sv
// mmac_tile_sequencer
//
// Sequences one shared multiply-accumulate datapath to compute
// C = sum over t of (A_t x B_t) for square M_SIZE x M_SIZE tiles.
// Operand pairs are loaded into internal A/B tile buffers. An i/j/k loop then
// runs one MAC per cycle, and results accumulate across num_tiles K-tiles.
// The result matrix streams out row-major with a valid/ready handshake.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active low
//   start      begin a job (sampled only when idle)
//   num_tiles  number of K-tiles to accumulate, captured on start
//   abort      synchronous job cancel (ignored when idle)
//   in_valid   operand beat valid
//   in_ready   operand beat accepted when in_valid && in_ready
//   in_a       A element, row-major
//   in_b       B element, row-major
//   out_valid  result element valid
//   out_ready  downstream accepts result
//   out_data   C element, row-major
//   out_last   high with the final C element
//   busy       high whenever a job is in progress
//   done       one-cycle pulse after the last output handshake

module mmac_tile_sequencer #(
    parameter int unsigned ELEM_W     = 8,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned M_SIZE     = 4,
    parameter int unsigned TILE_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TILE_CNT_W-1:0] num_tiles,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ELEM_W-1:0]     in_a,
    input  logic [ELEM_W-1:0]     in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned LOG_M = $clog2(M_SIZE);
    localparam int unsigned NELEM = M_SIZE * M_SIZE;
    localparam int unsigned IDX_W = 2 * LOG_M;
    localparam int unsigned MAC_W = 3 * LOG_M;
    localparam int unsigned PROD_W = 2 * ELEM_W;

    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NELEM - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
    localparam logic [MAC_W-1:0]      MAC_ONE  = MAC_W'(1);
    localparam logic [MAC_W-1:0]      MAC_LAST = {MAC_W{1'b1}};
    localparam logic [TILE_CNT_W-1:0] TILE_ONE = TILE_CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StComp,
        StDrain
    } state_e;

    state_e state_q, state_d;

    logic [TILE_CNT_W-1:0] num_tiles_q;
    logic [TILE_CNT_W-1:0] tile_cnt_q;
    // Shared element index: load position in LOAD, output position in DRAIN.
    logic [IDX_W-1:0]      idx_q;
    // MAC loop counter laid out as {i, j, k}, so k is innermost and i outermost.
    logic [MAC_W-1:0]      mac_cnt_q;
    logic                  done_q;

    logic [ELEM_W-1:0] abuf [NELEM];
    logic [ELEM_W-1:0] bbuf [NELEM];
    logic [ACC_W-1:0]  acc  [NELEM];

    // Control strobes from the next-state logic.
    logic job_start;
    logic load_we;
    logic mac_en;
    logic drain_adv;
    logic done_d;

    // MAC datapath
    logic [LOG_M-1:0]  mi, mj, mk;
    logic [IDX_W-1:0]  a_idx, b_idx, acc_idx;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext;
    logic              last_mac;
    logic [TILE_CNT_W:0] tile_next;
    logic              more_tiles;

    assign mi = mac_cnt_q[MAC_W-1 -: LOG_M];
    assign mj = mac_cnt_q[2*LOG_M-1 -: LOG_M];
    assign mk = mac_cnt_q[LOG_M-1:0];

    assign a_idx   = {mi, mk};
    assign b_idx   = {mk, mj};
    assign acc_idx = {mi, mj};

    assign prod     = PROD_W'(abuf[a_idx]) * PROD_W'(bbuf[b_idx]);
    // Zero-extends or truncates the product to the accumulator width.
    assign prod_ext = ACC_W'(prod);

    assign last_mac   = (mac_cnt_q == MAC_LAST);
    assign tile_next  = {1'b0, tile_cnt_q} + (TILE_CNT_W + 1)'(1);
    assign more_tiles = (tile_next < {1'b0, num_tiles_q});

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        job_start = 1'b0;
        load_we   = 1'b0;
        mac_en    = 1'b0;
        drain_adv = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    job_start = 1'b1;
                    state_d   = (num_tiles == '0) ? StDrain : StLoad;
                end
            end
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_we = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = StComp;
                    end
                end
            end
            StComp: begin
                mac_en = 1'b1;
                if (last_mac) begin
                    state_d = more_tiles ? StLoad : StDrain;
                end
            end
            StDrain: begin
                out_valid = 1'b1;
                out_data  = acc[idx_q];
                out_last  = (idx_q == IDX_LAST);
                if (out_ready) begin
                    drain_adv = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over everything in the same cycle: no beat is taken, no
        // result is handed over and no done is raised.
        if (abort && state_q != StIdle) begin
            state_d   = StIdle;
            in_ready  = 1'b0;
            out_valid = 1'b0;
            out_last  = 1'b0;
            load_we   = 1'b0;
            mac_en    = 1'b0;
            drain_adv = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            num_tiles_q <= '0;
            tile_cnt_q  <= '0;
            idx_q       <= '0;
            mac_cnt_q   <= '0;
            done_q      <= 1'b0;
            abuf        <= '{default: '0};
            bbuf        <= '{default: '0};
            acc         <= '{default: '0};
        end else begin
            state_q <= state_d;
            done_q  <= done_d;

            if (job_start) begin
                num_tiles_q <= num_tiles;
                tile_cnt_q  <= '0;
                idx_q       <= '0;
                mac_cnt_q   <= '0;
                acc         <= '{default: '0};
            end

            if (load_we) begin
                abuf[idx_q] <= in_a;
                bbuf[idx_q] <= in_b;
                // Wraps to zero after the last element, ready for the next phase.
                idx_q       <= idx_q + IDX_ONE;
            end

            if (mac_en) begin
                acc[acc_idx] <= acc[acc_idx] + prod_ext;
                mac_cnt_q    <= mac_cnt_q + MAC_ONE;
                if (last_mac) begin
                    tile_cnt_q <= tile_cnt_q + TILE_ONE;
                end
            end

            if (drain_adv) begin
                idx_q <= idx_q + IDX_ONE;
            end
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_mmac_tile_sequencer.sv
module tb_mmac_tile_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0, start16 = 1'b0, abort = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] num_tiles = '0, in_a = '0, in_b = '0;

    logic        in_ready, out_valid, out_last, busy, done;
    logic [31:0] out_data;
    logic        in_ready16, out_valid16, out_last16, busy16, done16;
    logic [15:0] out_data16;

    mmac_tile_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    mmac_tile_sequencer #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .num_tiles(num_tiles), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
        .out_last(out_last16), .busy(busy16), .done(done16)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    int ta [4][16];
    int tb_m [4][16];
    longint expc [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // C[i][j] = sum_t sum_k A_t[i][k] * B_t[k][j], modulo 2^accw.
    task automatic model(input int nt, input int accw);
        longint mask;
        mask = (64'd1 << accw) - 1;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                longint s;
                s = 0;
                for (int t = 0; t < nt; t++)
                    for (int k = 0; k < 4; k++)
                        s += longint'(ta[t][i*4+k]) * longint'(tb_m[t][k*4+j]);
                expc[i*4+j] = s & mask;
            end
    endtask

    task automatic load_identity();
        for (int e = 0; e < 16; e++) begin
            ta[0][e]   = (e / 4 == e % 4) ? 1 : 0;
            tb_m[0][e] = e + 1;
        end
    endtask

    // Runs one job. bub/stl are percentages of input bubbles / output stalls.
    // cut > 0 returns early after that many output handshakes.
    task automatic run_job(input string name, input int nt, input int bub, input int stl,
                           input bit use16, input bit timed, input int cut);
        int s, tile, beat, n, first_ov, rises, guard;
        logic ir, ov, ol, bz, dn, prev_ir, stalled;
        logic [31:0] od, prev_d;
        bit busy_ok, early_done;

        model(nt, use16 ? 16 : 32);
        if (use16) start16 = 1'b1; else start = 1'b1;
        num_tiles = 8'(nt);
        s = cyc;
        step();
        start = 1'b0;
        start16 = 1'b0;
        num_tiles = 8'($urandom);  // must be ignored after capture
        tile = 0; beat = 0; n = 0; first_ov = -1; rises = 0; guard = 0;
        prev_ir = 1'b0; stalled = 1'b0; prev_d = '0; busy_ok = 1; early_done = 0;

        while (n < 16) begin
            guard++;
            if (guard > 4000) begin
                n_cmp++; n_bad++;
                $display("FAIL %s timeout: %0d outputs seen, 16 required", name, n);
                in_valid = 1'b0; out_ready = 1'b0;
                return;
            end
            in_valid  = (tile < nt) && ($urandom_range(99) >= bub);
            in_a      = (tile < nt) ? 8'(ta[tile][beat]) : 8'd0;
            in_b      = (tile < nt) ? 8'(tb_m[tile][beat]) : 8'd0;
            out_ready = ($urandom_range(99) >= stl);
            #1;
            ir = use16 ? in_ready16 : in_ready;
            ov = use16 ? out_valid16 : out_valid;
            ol = use16 ? out_last16 : out_last;
            bz = use16 ? busy16 : busy;
            dn = use16 ? done16 : done;
            od = use16 ? 32'(out_data16) : out_data;
            if (timed && nt > 0 && cyc == s + 1) begin
                n_cmp++;
                if (ir !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s first_in_ready: got %b at S+1, want 1", name, ir);
                end
            end
            if (ir && !prev_ir) rises++;
            prev_ir = ir;
            if (!bz) busy_ok = 0;
            if (dn) early_done = 1;
            if (ir && in_valid) begin
                beat++;
                if (beat == 16) begin beat = 0; tile++; end
            end
            if (ov) begin
                if (first_ov < 0) first_ov = cyc;
                if (stalled) begin
                    n_cmp++;
                    if (od !== prev_d) begin
                        n_bad++;
                        $display("FAIL %s stall_hold[%0d]: got %0d, want %0d", name, n, od, prev_d);
                    end
                end
                if (out_ready) begin
                    n_cmp++;
                    if (longint'(od) !== expc[n]) begin
                        n_bad++;
                        $display("FAIL %s data[%0d]: got %0d, want %0d", name, n, od, expc[n]);
                    end
                    n_cmp++;
                    if (ol !== (n == 15)) begin
                        n_bad++;
                        $display("FAIL %s last[%0d]: got %b, want %b", name, n, ol, (n == 15));
                    end
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev_d = od;
                end
            end
            if (cut > 0 && n == cut) begin
                step();
                return;
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;

        dn = use16 ? done16 : done;
        bz = use16 ? busy16 : busy;
        n_cmp++;
        if (dn !== 1'b1) begin
            n_bad++; $display("FAIL %s done_pulse: got %b, want 1", name, dn);
        end
        n_cmp++;
        if (bz !== 1'b0) begin
            n_bad++; $display("FAIL %s busy_after: got %b, want 0", name, bz);
        end
        n_cmp++;
        if (!busy_ok || early_done) begin
            n_bad++;
            $display("FAIL %s busy_window: busy_ok=%0d early_done=%0d, want 1/0", name, busy_ok,
                     early_done);
        end
        n_cmp++;
        if (rises !== nt || tile !== nt) begin
            n_bad++;
            $display("FAIL %s in_ready_rises/tiles: got %0d/%0d, want %0d/%0d", name, rises, tile,
                     nt, nt);
        end
        if (timed) begin
            n_cmp++;
            if (first_ov - s !== 1 + nt * 80) begin
                n_bad++;
                $display("FAIL %s first_out_latency: got %0d, want %0d", name, first_ov - s,
                         1 + nt * 80);
            end
            n_cmp++;
            if (cyc - s !== 1 + nt * 80 + 16) begin
                n_bad++;
                $display("FAIL %s done_latency: got %0d, want %0d", name, cyc - s, 1 + nt * 80 + 16);
            end
        end
        step();
        dn = use16 ? done16 : done;
        n_cmp++;
        if (dn !== 1'b0) begin
            n_bad++; $display("FAIL %s done_width: got %b, want 0", name, dn);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_cmp++;
        if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || out_data !== 32'd0) begin
            n_bad++;
            $display("FAIL %s idle_outputs: got ir=%b ov=%b ol=%b bz=%b dn=%b d=%0d, want all 0",
                     name, in_ready, out_valid, out_last, busy, done, out_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        check_idle_outputs("reset");
    endtask

    task automatic test_identity();
        load_identity();
        run_job("identity", 1, 0, 0, 0, 1, 0);
    endtask

    task automatic test_accumulate();
        for (int t = 0; t < 2; t++)
            for (int e = 0; e < 16; e++) begin
                ta[t][e] = 1;
                tb_m[t][e] = 2;
            end
        run_job("accumulate", 2, 0, 0, 0, 1, 0);
    endtask

    task automatic test_backpressure();
        load_identity();
        run_job("backpressure", 1, 30, 50, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 3; t++)
            for (int e = 0; e < 16; e++) begin
                ta[t][e] = int'($urandom_range(255));
                tb_m[t][e] = int'($urandom_range(255));
            end
        run_job("random3", 3, 20, 30, 0, 0, 0);
    endtask

    task automatic test_wrap();
        for (int e = 0; e < 16; e++) begin
            ta[0][e] = 255;
            tb_m[0][e] = 255;
        end
        run_job("wrap16", 1, 0, 0, 1, 1, 0);
    endtask

    task automatic test_zero_abort();
        bit seen;
        run_job("zero_tiles", 0, 0, 0, 0, 1, 0);
        load_identity();
        start = 1'b1;
        num_tiles = 8'd1;
        step();
        start = 1'b0;
        for (int e = 0; e < 16; e++) begin
            in_valid = 1'b1;
            in_a = 8'(ta[0][e]);
            in_b = 8'(tb_m[0][e]);
            step();
        end
        in_valid = 1'b0;
        repeat (10) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_to_idle: got busy=%b ir=%b ov=%b, want 0/0/0", busy, in_ready,
                     out_valid);
        end
        seen = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 120; c++) begin
            if (out_valid || done) seen = 1;
            step();
        end
        out_ready = 1'b0;
        n_cmp++;
        if (seen) begin
            n_bad++; $display("FAIL abort_quiet: got output/done activity, want none");
        end
        test_identity();
    endtask

    task automatic test_reset_mid();
        load_identity();
        run_job("reset_mid_pre", 1, 0, 0, 0, 0, 5);
        rst = 1'b0;
        out_ready = 1'b0;
        step();
        check_idle_outputs("reset_mid");
        rst = 1'b1;
        step();
        step();
        check_idle_outputs("reset_mid_nodone");
        test_identity();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_accumulate();
        test_backpressure();
        test_random();
        test_wrap();
        test_zero_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmac_tile_sequencer.md
Name: mmac_tile_sequencer

Overview:
Controller that sequences a single shared multiply-accumulate datapath to compute C = sum over t of (A_t x B_t), with square M_SIZE x M_SIZE operand tiles.
- Operand tiles stream in element-pair by element-pair.
- The block runs the i/j/k MAC loop over its internal tile buffers and accumulates across num_tiles K-tiles.
- The result matrix streams out element by element.
- It sits between the operand fetch logic and the result writeback, and owns clear/accumulate sequencing for the MAC engine.

Parameters:
- ELEM_W, 8, width of each unsigned A/B element.
- ACC_W, 32, width of each accumulator element; sums wrap modulo 2^ACC_W.
- M_SIZE, 4, matrix dimension; must be a power of two.
- TILE_CNT_W, 8, width of num_tiles.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  begin job; sampled only in IDLE
- num_tiles  in  TILE_CNT_W  number of K-tiles to accumulate; captured on start
- abort  in  1  synchronous job cancel
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid && in_ready
- in_a  in  ELEM_W  A element, row-major order
- in_b  in  ELEM_W  B element, row-major order
- out_valid  out  1  result element valid
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_W  C element, row-major order
- out_last  out  1  high with the final C element
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after the last output handshake

Behaviour:
- Clock and reset: clk is the clock; reset rst is synchronous, active-low.
- Reset values:
  - state = IDLE.
  - in_ready, out_valid, out_last, busy, done = 0; out_data = 0.
  - All accumulators, tile buffers and counters = 0.
  - A reset asserted in any state returns to IDLE on the next edge; no done is produced.
- States: IDLE, LOAD, COMP, DRAIN.
- IDLE:
  - On start=1, capture num_tiles, clear all M_SIZE^2 accumulators, clear tile_cnt.
  - Go to LOAD, or to DRAIN if num_tiles==0. In that case 16 zeros are output for M_SIZE=4.
- LOAD:
  - in_ready=1.
  - Each handshake writes Abuf[idx/M][idx%M]=in_a and Bbuf[idx/M][idx%M]=in_b, then idx++.
  - Bubbles (in_valid=0) are allowed and do not advance idx.
  - After the M^2-th handshake: in_ready drops, idx=0, next state COMP.
- COMP:
  - in_ready=0.
  - Exactly M^3 cycles, one MAC per cycle, loop order i outer, j middle, k inner.
  - Each cycle: acc[i][j] <= acc[i][j] + Abuf[i][k]*Bbuf[k][j].
  - Product is 2*ELEM_W bits, zero-extended or truncated to ACC_W; the sum wraps modulo 2^ACC_W.
  - On the final cycle (i=j=k=M-1), tile_cnt++. If tile_cnt+1 < num_tiles, go to LOAD; else go to DRAIN.
  - Accumulators are never cleared between tiles.
- DRAIN:
  - out_valid=1; out_data = acc[idx/M][idx%M]; out_last = (idx==M^2-1).
  - idx advances only on out_valid && out_ready.
  - out_data/out_last are held stable while out_ready=0.
  - After the last handshake: out_valid=0, go to IDLE, done=1 for exactly one cycle.
- Timing for an uninterrupted job (no bubbles, no backpressure):
  - start at cycle S; first in_ready at S+1.
  - Each tile takes M^2 + M^3 cycles (80 for M=4).
  - First out_valid at S+1+num_tiles*80.
  - done at S+1+num_tiles*80+16.
- busy is high from S+1 through the cycle of the last output handshake.
- abort:
  - Any non-IDLE state goes to IDLE next cycle; all handshake outputs deassert.
  - No done pulse; accumulators are left stale and cleared by the next start.
  - abort in IDLE is ignored. abort has priority over start in the same cycle.
- start while busy is ignored. num_tiles changes after capture have no effect.
- Input beats presented outside LOAD are not accepted (in_ready=0).

Test Plan:
- Identity: A=I, B = elements 1..16 row-major, num_tiles=1 -> outputs 1..16 in order, out_last on the 16th, done one cycle after, first out_valid 81 cycles after start.
- Accumulate: two tiles, each with A=all 1 and B=all 2, num_tiles=2 -> all 16 outputs = 16 (8 per tile); in_ready re-asserts exactly once, after the first COMP.
- Backpressure and bubbles: random in_valid gaps, out_ready toggled 50% -> same results as the identity test; out_data stable while stalled; no beat lost or duplicated.
- Wrap: ACC_W=16, A and B all 255, num_tiles=1 -> every output = 260100 mod 65536 = 63492.
- Zero tiles, then abort: num_tiles=0 -> 16 zeros, done pulse. Next, start a 1-tile job and assert abort during COMP -> IDLE next cycle, no out_valid, no done. Then rerun identity -> correct 1..16, no stale accumulation.
- Reset mid-operation: rst=0 during DRAIN after 5 outputs -> all outputs at reset values next edge; a subsequent job is correct.
